bitcount_sorter: RTL and testbench



---
 rtl/sorter_pkg.sv | 12 +
 rtl/bitcount_sorter_cmp_swap.sv | 15 +
 rtl/bitcount_sorter.sv | 152 +++++++++++++++
 tb/tb_bitcount_sorter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared constants and state encoding for the count sorter, kept in step with
// the bit-count stage so both agree on the count width.
package sorter_pkg;
  localparam int K_DEF = 4;
  localparam int M_DEF = 8;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SORT    = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;
endpackage

// File: rtl/bitcount_sorter_cmp_swap.sv
// Single unsigned compare-exchange: orders a pair, flags whether it was out of order.
module cmp_swap #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] lo,
  output logic [K-1:0] hi,
  output logic         swapped
);
  // Strict compare so equal values keep their positions.
  assign swapped = (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;
endmodule

// File: rtl/bitcount_sorter.sv
// Collects M counts, bubble-sorts them one compare per cycle, then streams the
// ascending result out over a valid/ready handshake.
module bitcount_sorter
  import sorter_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int M  = M_DEF,
  parameter int AW = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] cnt_in,
  input  logic         cnt_valid,
  output logic         in_ready,
  output logic         in_drop,
  output logic         sort_busy,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);
  state_e         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [AW-1:0]  pass_q, pass_d;
  logic           swap_flag_q, swap_flag_d;
  logic [K-1:0]   mem_q [M];
  logic [K-1:0]   mem_d [M];
  logic [K-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           in_ready_q, in_ready_d;
  logic           sort_busy_q, sort_busy_d;

  logic [AW-1:0]  idx_p1;
  logic [AW:0]    pass_nxt;
  logic [K-1:0]   cs_lo, cs_hi;
  logic           cs_swapped;

  assign idx_p1   = idx_q + AW'(1);
  assign pass_nxt = {1'b0, pass_q} + (AW+1)'(1);

  cmp_swap #(.K(K)) u_cmp_swap (
    .a       (mem_q[idx_q]),
    .b       (mem_q[idx_p1]),
    .lo      (cs_lo),
    .hi      (cs_hi),
    .swapped (cs_swapped)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    swap_flag_d = swap_flag_q;
    mem_d       = mem_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_COLLECT: begin
        if (cnt_valid) begin
          mem_d[wr_ptr_q] = cnt_in;
          if (wr_ptr_q == AW'(M-1)) begin
            wr_ptr_d    = '0;
            idx_d       = '0;
            pass_d      = '0;
            swap_flag_d = 1'b0;
            state_d     = S_SORT;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      S_SORT: begin
        mem_d[idx_q]  = cs_lo;
        mem_d[idx_p1] = cs_hi;
        if (idx_q == AW'(M-2)) begin
          pass_d = pass_nxt[AW-1:0];
          if (!(swap_flag_q || cs_swapped) || (pass_nxt == (AW+1)'(M-1))) begin
            // Present entry 0 of the post-swap array so out_valid and data rise together.
            state_d    = S_OUTPUT;
            rd_ptr_d   = '0;
            out_data_d = mem_d[0];
            out_last_d = 1'b0;
          end else begin
            idx_d       = '0;
            swap_flag_d = 1'b0;
          end
        end else begin
          idx_d       = idx_p1;
          swap_flag_d = swap_flag_q || cs_swapped;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = S_COLLECT;
            out_last_d = 1'b0;
          end else begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            out_data_d = mem_q[rd_ptr_q + AW'(1)];
            out_last_d = ((rd_ptr_q + AW'(1)) == AW'(M-1));
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
    out_valid_d = (state_d == S_OUTPUT);
    in_ready_d  = (state_d == S_COLLECT);
    sort_busy_d = (state_d == S_SORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      swap_flag_q <= 1'b0;
      for (int i = 0; i < M; i++) mem_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      sort_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      swap_flag_q <= swap_flag_d;
      mem_q       <= mem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      sort_busy_q <= sort_busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign in_drop   = cnt_valid && !in_ready_q;
  assign sort_busy = sort_busy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_bitcount_sorter.sv
// Directed bench for bitcount_sorter: sort results, sort latency, drops, stalls, reset.
module tb_bitcount_sorter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       cnt_valid = 1'b0;
  logic       in_ready, in_drop, sort_busy, out_valid, out_last;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int n;

  typedef logic [3:0] vec_t [8];
  vec_t in1, ex1, asc, desc, eights;

  always #5 clk = ~clk;

  bitcount_sorter #(.K(4), .M(8), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .in_ready  (in_ready),
    .in_drop   (in_drop),
    .sort_busy (sort_busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_batch(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      cnt_in    = v[i];
      cnt_valid = 1'b1;
      tick();
    end
    cnt_valid = 1'b0;
  endtask

  task automatic run_sort(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (sort_busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input vec_t e, input bit stall);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < 8 && cyc < 100) begin
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      tests++;
      if (out_valid !== 1'b1) begin
        fails++;
        $error("FAIL out_valid: observed %0h expected 1", out_valid);
      end
      tests++;
      if (out_data !== e[idx]) begin
        fails++;
        $error("FAIL out_data: observed %0h expected %0h", out_data, e[idx]);
      end
      tests++;
      if (out_last !== (idx == 7)) begin
        fails++;
        $error("FAIL out_last: observed %0h expected %0h", out_last, (idx == 7));
      end
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_count", idx, 8);
    chk("done_out_valid", out_valid, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_in_drop", in_drop, 1'b0);
    chk("rst_sort_busy", sort_busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
  endtask

  initial begin
    in1    = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd0};
    ex1    = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    asc    = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    desc   = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    eights = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};

    tick();
    tick();
    check_reset_state();
    rst_n = 1'b1;
    tick();

    // Mixed batch, consumer always ready.
    push_batch(in1);
    chk("sort_in_ready", in_ready, 1'b0);
    chk("sort_busy_on", sort_busy, 1'b1);
    run_sort(n);
    chk("mixed_sort_cycles", n, 49);
    drain(ex1, 1'b0);

    // Already sorted: single pass.
    tick();
    push_batch(asc);
    run_sort(n);
    chk("asc_sort_cycles", n, 7);
    drain(asc, 1'b0);

    // Strictly descending: worst case.
    tick();
    push_batch(desc);
    run_sort(n);
    chk("desc_sort_cycles", n, 49);
    drain(asc, 1'b0);

    // Drops during SORT and OUTPUT, then a stalling consumer.
    tick();
    push_batch(in1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cnt_in    = 4'hF;
      cnt_valid = 1'b1;
      #1;
      chk("drop_in_sort", in_drop, 1'b1);
      chk("busy_while_drop", sort_busy, 1'b1);
      tick();
      cnt_valid = 1'b0;
    end
    run_sort(n);
    chk("drop_sort_bound", (n < 200), 1'b1);
    cnt_valid = 1'b1;
    #1;
    chk("drop_in_output", in_drop, 1'b1);
    tick();
    cnt_valid = 1'b0;
    #1;
    chk("drop_cleared", in_drop, 1'b0);
    @(negedge clk);
    drain(ex1, 1'b1);

    // Reset in the middle of a sort.
    tick();
    push_batch(desc);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_busy", sort_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset after a partial batch of four entries.
    for (int i = 0; i < 4; i++) begin
      cnt_in    = desc[i];
      cnt_valid = 1'b1;
      tick();
    end
    cnt_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh batch of equal values: no swaps, one pass.
    push_batch(eights);
    run_sort(n);
    chk("eights_sort_cycles", n, 7);
    drain(eights, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
